life_step_ctrl: RTL and testbench

//  Sequences one Game-of-Life generation over a FIELD_W x FIELD_H field held in two
//  bit-per-cell banks (ping-pong). Walks every cell in raster order and issues up to
//  9 reads (8 neighbours + self) from the current bank. Counts live neighbours, applies
//  B3/S23 and writes the next state to the other bank. Sits between the top-level

---
 rtl/life_pkg.sv | 10 +
 rtl/get_nbrs_address.sv | 37 +++
 rtl/life_step_ctrl.sv | 118 +++++++++++
 tb/tb_life_step_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared Game-of-Life step constants, FSM state type and B3/S23 rule
package life_pkg;
  localparam int NEIGHBOURS_CNT = 8;
  localparam int BIRTH_CNT = 3;
  localparam int SURVIVE_CNT = 2;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, WRITE, DONE} step_state_t;
  function automatic logic life_rule(input logic self, input logic [3:0] cnt);
    return (cnt == 4'(BIRTH_CNT)) || (self && cnt == 4'(SURVIVE_CNT));
  endfunction
endpackage

// File: rtl/get_nbrs_address.sv
// get_nbrs_address: neighbour coordinates and relevance flags of one cell (LIFE_TORUS_EN makes every neighbour relevant)
module get_nbrs_address
  import life_pkg::*;
#(
  parameter int FIELD_W = 50,
  parameter int FIELD_H = 50,
  localparam int XW = $clog2(FIELD_W),
  localparam int YW = $clog2(FIELD_H)
) (
  input  logic [XW-1:0]                     cx_i,
  input  logic [YW-1:0]                     cy_i,
  output logic [NEIGHBOURS_CNT-1:0][XW-1:0] nx_o,
  output logic [NEIGHBOURS_CNT-1:0][YW-1:0] ny_o,
  output logic [NEIGHBOURS_CNT-1:0]         rel_o
);
  logic [XW-1:0] xm, xp;
  logic [YW-1:0] ym, yp;
  logic xl, xh, yl, yh;
  // wrapped neighbour coordinates in slot order 0 1 2 / 3 x 4 / 5 6 7
  always_comb begin
    xl = cx_i == '0;
    xh = cx_i == XW'(FIELD_W - 1);
    yl = cy_i == '0;
    yh = cy_i == YW'(FIELD_H - 1);
    xm = xl ? XW'(FIELD_W - 1) : cx_i - XW'(1);
    xp = xh ? '0 : cx_i + XW'(1);
    ym = yl ? YW'(FIELD_H - 1) : cy_i - YW'(1);
    yp = yh ? '0 : cy_i + YW'(1);
    nx_o = {xp, cx_i, xm, xp, xm, xp, cx_i, xm};
    ny_o = {yp, yp, yp, cy_i, cy_i, ym, ym, ym};
`ifdef LIFE_TORUS_EN
    rel_o = '1;
`else
    rel_o = {~xh & ~yh, ~yh, ~xl & ~yh, ~xh, ~xl, ~xh & ~yl, ~yl, ~xl & ~yl};
`endif
  end
endmodule

// File: rtl/life_step_ctrl.sv
// life_step_ctrl: sequences one B3/S23 generation over a ping-pong bit-per-cell field (LIFE_TORUS_EN selects torus wrap)
module life_step_ctrl
  import life_pkg::*;
#(
  parameter int FIELD_W = 50,
  parameter int FIELD_H = 50,
  localparam int XW = $clog2(FIELD_W),
  localparam int YW = $clog2(FIELD_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_buf_sel,
  output logic          o_rd_en,
  output logic [XW-1:0] o_rd_x,
  output logic [YW-1:0] o_rd_y,
  input  logic          i_rd_data,
  output logic          o_wr_en,
  output logic [XW-1:0] o_wr_x,
  output logic [YW-1:0] o_wr_y,
  output logic          o_wr_data,
  output logic [15:0]   o_gen_cnt
);
  step_state_t state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [3:0] slot_q, cnt_q;
  logic self_q, rv_q, rv_self_q, busy_q, done_q, buf_q;
  logic [15:0] gen_q;
  logic [NEIGHBOURS_CNT-1:0][XW-1:0] nx;
  logic [NEIGHBOURS_CNT-1:0][YW-1:0] ny;
  logic [NEIGHBOURS_CNT-1:0] rel;
  logic self_slot, last_x, last_cell;

  get_nbrs_address #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) u_nbrs (
    .cx_i (x_q),
    .cy_i (y_q),
    .nx_o (nx),
    .ny_o (ny),
    .rel_o(rel)
  );

  // slot mux onto the read port, write port decode; idle ports are held at zero
  always_comb begin
    self_slot = slot_q == 4'(NEIGHBOURS_CNT);
    last_x = x_q == XW'(FIELD_W - 1);
    last_cell = last_x && y_q == YW'(FIELD_H - 1);
    o_rd_en = state_q == SCAN && (self_slot || rel[slot_q[2:0]]);
    o_rd_x = o_rd_en ? (self_slot ? x_q : nx[slot_q[2:0]]) : '0;
    o_rd_y = o_rd_en ? (self_slot ? y_q : ny[slot_q[2:0]]) : '0;
    o_wr_en = state_q == WRITE;
    o_wr_x = o_wr_en ? x_q : '0;
    o_wr_y = o_wr_en ? y_q : '0;
    o_wr_data = o_wr_en && life_rule(self_q, cnt_q);
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_buf_sel = buf_q;
  assign o_gen_cnt = gen_q;

  // cell walk FSM with read-data accumulation one cycle behind each read strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      slot_q <= '0;
      cnt_q <= '0;
      self_q <= 1'b0;
      rv_q <= 1'b0;
      rv_self_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      buf_q <= 1'b0;
      gen_q <= '0;
    end else begin
      rv_q <= o_rd_en;
      rv_self_q <= o_rd_en && self_slot;
      if (rv_q && rv_self_q) self_q <= i_rd_data;
      else if (rv_q) cnt_q <= cnt_q + 4'(i_rd_data);
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= SCAN;
          busy_q <= 1'b1;
          x_q <= '0;
          y_q <= '0;
          slot_q <= '0;
        end
        SCAN: begin
          state_q <= self_slot ? DRAIN : SCAN;
          slot_q <= self_slot ? '0 : slot_q + 4'd1;
        end
        DRAIN: state_q <= WRITE;
        WRITE: begin
          cnt_q <= '0;
          self_q <= 1'b0;
          state_q <= last_cell ? DONE : SCAN;
          x_q <= last_x ? '0 : x_q + XW'(1);
          y_q <= last_cell ? '0 : (last_x ? y_q + YW'(1) : y_q);
          if (last_cell) begin
            done_q <= 1'b1;
            buf_q <= ~buf_q;
            gen_q <= gen_q + 16'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_step_ctrl.sv
// tb_life_step_ctrl: directed generation vectors on a 4x4 field plus a 5x3 timing run (LIFE_TORUS_EN aware)
module tb_life_step_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, buf_a, rd_en_a, rd_data_a, wr_en_a, wr_data_a;
  logic [1:0] rd_x_a, rd_y_a, wr_x_a, wr_y_a;
  logic [15:0] gen_a;
  logic busy_b, done_b, buf_b, rd_en_b, rd_data_b, wr_en_b, wr_data_b;
  logic [2:0] rd_x_b, wr_x_b;
  logic [1:0] rd_y_b, wr_y_b;
  logic [15:0] gen_b;

  life_step_ctrl #(.FIELD_W(4), .FIELD_H(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_buf_sel(buf_a), .o_rd_en(rd_en_a), .o_rd_x(rd_x_a), .o_rd_y(rd_y_a),
    .i_rd_data(rd_data_a), .o_wr_en(wr_en_a), .o_wr_x(wr_x_a), .o_wr_y(wr_y_a),
    .o_wr_data(wr_data_a), .o_gen_cnt(gen_a)
  );

  life_step_ctrl #(.FIELD_W(5), .FIELD_H(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_buf_sel(buf_b), .o_rd_en(rd_en_b), .o_rd_x(rd_x_b), .o_rd_y(rd_y_b),
    .i_rd_data(rd_data_b), .o_wr_en(wr_en_b), .o_wr_x(wr_x_b), .o_wr_y(wr_y_b),
    .o_wr_data(wr_data_b), .o_gen_cnt(gen_b)
  );

`ifdef LIFE_TORUS_EN
  localparam int RD_GEN = 144, RD_CELL0 = 9, RD_B = 135;
  localparam logic [15:0] EXP_WRAP = 16'h9009;
`else
  localparam int RD_GEN = 100, RD_CELL0 = 4, RD_B = 91;
  localparam logic [15:0] EXP_WRAP = 16'h0000;
`endif

  logic [15:0] bank [2];
  logic load = 1'b0;
  logic [15:0] load_val = '0;
  always @(posedge clk) begin
    if (load) begin
      bank[0] <= load_val;
      bank[1] <= '0;
    end else if (wr_en_a) bank[~buf_a][{wr_y_a, wr_x_a}] <= wr_data_a;
    if (rd_en_a) rd_data_a <= bank[buf_a][{rd_y_a, rd_x_a}];
  end

  always @(posedge clk) rd_data_b <= 1'b0;

  int n_vec = 0, n_err = 0;
  int lat, wrs, rds, rdf, ovl, ones, dones;

  typedef struct {
    string nm;
    logic [15:0] init;
    logic [15:0] exp;
    int gens;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_gen(input bit hold);
    @(negedge clk);
    start_a = 1'b1;
    lat = 0; wrs = 0; rds = 0; rdf = 0; ovl = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) start_a = 1'b0;
      if (rd_en_a) begin
        rds++;
        if (wrs == 0) rdf++;
      end
      if (wr_en_a) wrs++;
      if (rd_en_a && wr_en_a) ovl++;
    end while (!done_a && lat < 1000);
    start_a = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"blinker", 16'h0070, 16'h0222, 1};
    vecs[1] = '{"block", 16'h0660, 16'h0660, 2};
    vecs[2] = '{"corner", 16'h0032, 16'h0033, 1};
    vecs[3] = '{"wrap", 16'h9008, EXP_WRAP, 1};
    do_reset();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_buf", buf_a, 0);
    chk("rst_ports", {rd_en_a, rd_x_a, rd_y_a, wr_en_a, wr_x_a, wr_y_a, wr_data_a}, 0);
    chk("rst_gen", gen_a, 0);

    @(negedge clk);
    start_b = 1'b1;
    lat = 0; wrs = 0; rds = 0; ones = 0;
    do begin
      @(negedge clk);
      lat++;
      start_b = 1'b0;
      if (rd_en_b) rds++;
      if (wr_en_b) begin
        wrs++;
        if (wr_data_b) ones++;
      end
    end while (!done_b && lat < 1000);
    chk("b_latency", lat, 166);
    chk("b_writes", wrs, 15);
    chk("b_reads", rds, RD_B);
    chk("b_live", ones, 0);
    chk("b_buf", buf_b, 1);
    chk("b_gen", gen_b, 1);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      do_load(vecs[i].init);
      for (int g = 0; g < vecs[i].gens; g++) begin
        run_gen(1'b0);
        chk({vecs[i].nm, "_latency"}, lat, 177);
        chk({vecs[i].nm, "_writes"}, wrs, 16);
        chk({vecs[i].nm, "_reads"}, rds, RD_GEN);
        chk({vecs[i].nm, "_cell0_reads"}, rdf, RD_CELL0);
        chk({vecs[i].nm, "_overlap"}, ovl, 0);
      end
      chk({vecs[i].nm, "_field"}, bank[vecs[i].gens % 2], vecs[i].exp);
      chk({vecs[i].nm, "_buf"}, buf_a, vecs[i].gens % 2);
      chk({vecs[i].nm, "_gen"}, gen_a, vecs[i].gens);
    end

    do_reset();
    do_load(16'h0070);
    run_gen(1'b1);
    chk("hold_latency", lat, 177);
    chk("hold_writes", wrs, 16);
    @(negedge clk);
    chk("hold_done_pulse", done_a, 0);
    @(negedge clk);
    chk("hold_idle", busy_a, 0);
    chk("hold_gen", gen_a, 1);
    chk("hold_field", bank[1], 16'h0222);

    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("mid_busy_before", busy_a, 1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy_a, 0);
    chk("mid_buf", buf_a, 0);
    chk("mid_gen", gen_a, 0);
    chk("mid_ports", {done_a, rd_en_a, rd_x_a, rd_y_a, wr_en_a, wr_x_a, wr_y_a, wr_data_a}, 0);
    dones = 0;
    repeat (250) begin
      @(negedge clk);
      if (done_a || busy_a) dones++;
    end
    chk("mid_no_done", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
